// File: rtl/vending_pkg.sv
// Shared types and coin encodings for the multi-product vending controller.
package vending_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VEND   = 2'd1,
        CHANGE = 2'd2
    } state_e;

    localparam int NICKLE_V  = 1;
    localparam int DIME_V    = 2;
    localparam int QUARTER_V = 5;

    localparam logic [2:0] CHG_NONE    = 3'b000;
    localparam logic [2:0] CHG_NICKLE  = 3'b001;
    localparam logic [2:0] CHG_DIME    = 3'b010;
    localparam logic [2:0] CHG_QUARTER = 3'b100;

endpackage

// File: rtl/vm_change_dispenser.sv
// Greedy change selector: picks the largest coin not exceeding the credit.
module vm_change_dispenser
    import vending_pkg::*;
#(
    parameter int CREDIT_W = 6
) (
    input  logic [CREDIT_W-1:0] credit_i,
    output logic [2:0]          coin_o,
    output logic [CREDIT_W-1:0] dec_o
);

    always_comb begin
        coin_o = CHG_NONE;
        dec_o  = '0;
        if (credit_i >= CREDIT_W'(QUARTER_V)) begin
            coin_o = CHG_QUARTER;
            dec_o  = CREDIT_W'(QUARTER_V);
        end else if (credit_i >= CREDIT_W'(DIME_V)) begin
            coin_o = CHG_DIME;
            dec_o  = CREDIT_W'(DIME_V);
        end else if (credit_i != '0) begin
            coin_o = CHG_NICKLE;
            dec_o  = CREDIT_W'(NICKLE_V);
        end
    end

endmodule

// File: rtl/vending_machine_multi.sv
// Multi-product vending controller: saturating nickel-unit credit, greedy serial change.
// Define VM_STOCK_EN to add per-item stock counters, restock_i and sold_out_o.
module vending_machine_multi
    import vending_pkg::*;
#(
    parameter int N_ITEMS    = 4,
    parameter int CREDIT_W   = 6,
    parameter int MAX_CREDIT = 40,
    parameter logic [N_ITEMS-1:0][CREDIT_W-1:0] PRICES = {6'd10, 6'd7, 6'd5, 6'd3},
`ifdef VM_STOCK_EN
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 10,
`endif
    localparam int SEL_W = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
`ifdef VM_STOCK_EN
    input  logic                restock_i,
    output logic [N_ITEMS-1:0]  sold_out_o,
`endif
    input  logic                nickle_i,
    input  logic                dime_i,
    input  logic                quarter_i,
    input  logic                select_valid_i,
    input  logic [SEL_W-1:0]    select_i,
    input  logic                cancel_i,
    output logic                vend_o,
    output logic [SEL_W-1:0]    vend_item_o,
    output logic [2:0]          change_o,
    output logic                coin_reject_o,
    output logic                deny_o,
    output logic [CREDIT_W-1:0] credit_o
);

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic                vend_q, vend_d, reject_q, reject_d, deny_q, deny_d;
    logic [2:0]          change_q, change_d;
    logic [2:0]          chg_coin;
    logic [CREDIT_W-1:0] chg_dec, coin_val, price;
    logic                coin_any, coin_multi, coin_ok, sel_in_range, stock_empty;

    vm_change_dispenser #(.CREDIT_W(CREDIT_W)) u_disp (
        .credit_i (credit_q),
        .coin_o   (chg_coin),
        .dec_o    (chg_dec)
    );

    always_comb begin
        coin_any   = nickle_i | dime_i | quarter_i;
        coin_multi = (nickle_i & dime_i) | (nickle_i & quarter_i) | (dime_i & quarter_i);
        coin_val   = '0;
        if (quarter_i)      coin_val = CREDIT_W'(QUARTER_V);
        else if (dime_i)    coin_val = CREDIT_W'(DIME_V);
        else if (nickle_i)  coin_val = CREDIT_W'(NICKLE_V);
        // Range check in int so the add can never wrap the credit register.
        coin_ok = (state_q == IDLE) && !coin_multi && !cancel_i && !select_valid_i
                  && ((int'(credit_q) + int'(coin_val)) <= MAX_CREDIT);
        sel_in_range = int'(select_i) < N_ITEMS;
        price        = sel_in_range ? PRICES[select_i] : '0;
    end

`ifdef VM_STOCK_EN
    logic [N_ITEMS-1:0][STOCK_W-1:0] stock_q, stock_d;
    logic [N_ITEMS-1:0]              sold_out_q, sold_out_d;
    logic                            stock_dec;

    assign stock_empty = sel_in_range && (stock_q[select_i] == '0);

    always_comb begin
        stock_d = stock_q;
        if (restock_i)
            stock_d = {N_ITEMS{STOCK_W'(STOCK_INIT)}};
        else if (stock_dec)
            stock_d[select_i] = stock_q[select_i] - STOCK_W'(1);
        for (int i = 0; i < N_ITEMS; i++) sold_out_d[i] = (stock_d[i] == '0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stock_q    <= {N_ITEMS{STOCK_W'(STOCK_INIT)}};
            sold_out_q <= '0;
        end else begin
            stock_q    <= stock_d;
            sold_out_q <= sold_out_d;
        end
    end

    assign sold_out_o = sold_out_q;
`else
    assign stock_empty = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        sel_d    = sel_q;
        vend_d   = 1'b0;
        deny_d   = 1'b0;
        change_d = CHG_NONE;
        reject_d = coin_any && !coin_ok;
`ifdef VM_STOCK_EN
        stock_dec = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (cancel_i && credit_q != '0) begin
                    state_d = CHANGE;
                end else if (select_valid_i) begin
                    if (!sel_in_range || stock_empty || credit_q < price) begin
                        deny_d = 1'b1;
                    end else begin
                        credit_d = credit_q - price;
                        sel_d    = select_i;
                        vend_d   = 1'b1;
                        state_d  = VEND;
`ifdef VM_STOCK_EN
                        stock_dec = 1'b1;
`endif
                    end
                end else if (coin_ok) begin
                    credit_d = credit_q + coin_val;
                end
            end
            VEND: state_d = (credit_q != '0) ? CHANGE : IDLE;
            CHANGE: begin
                change_d = chg_coin;
                credit_d = credit_q - chg_dec;
                if (credit_q == chg_dec) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            credit_q <= '0;
            sel_q    <= '0;
            vend_q   <= 1'b0;
            deny_q   <= 1'b0;
            reject_q <= 1'b0;
            change_q <= CHG_NONE;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            sel_q    <= sel_d;
            vend_q   <= vend_d;
            deny_q   <= deny_d;
            reject_q <= reject_d;
            change_q <= change_d;
        end
    end

    assign vend_o        = vend_q;
    assign vend_item_o   = vend_q ? sel_q : '0;
    assign change_o      = change_q;
    assign coin_reject_o = reject_q;
    assign deny_o        = deny_q;
    assign credit_o      = credit_q;

endmodule
